// File: rtl/pipeline_pkg.sv
// -----------------------------------------------------------------------------
// pipeline_pkg
//   Shared constants and types for the instruction fetch path of the 5-stage
//   MIPS pipeline.
//
//   WORD_W        : machine word width
//   NOP_INSN      : instruction word presented to decode when nothing is queued
//   ACCESS_WORD   : IMEM access-size encoding for a full word
//   RW_READ       : IMEM read/write encoding for a read
//   fetch_entry_t : one buffered fetch, {pc, insn}
// -----------------------------------------------------------------------------
package pipeline_pkg;

   localparam int unsigned WORD_W      = 32;
   localparam logic [31:0] NOP_INSN    = 32'h0000_0000;
   localparam logic [1:0]  ACCESS_WORD = 2'b00;
   localparam logic        RW_READ     = 1'b1;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] insn;
   } fetch_entry_t;

endpackage

// File: rtl/fetchq_fifo.sv
// -----------------------------------------------------------------------------
// fetchq_fifo
//   Synchronous FIFO of fetch_entry_t with a single-cycle flush. The head entry
//   is read straight from storage (no write-to-read bypass), so a pushed entry
//   becomes visible the cycle after the push.
//
//   Ports:
//     i_clock  : rising-edge clock
//     i_reset  : synchronous active-high reset, empties the FIFO
//     i_flush  : empties the FIFO at the next edge; overrides push and pop
//     i_push   : write i_data at the tail
//     i_data   : entry to write
//     i_pop    : remove the head entry
//     o_head   : current head entry (contents undefined when empty)
//     o_empty  : no entries stored
//     o_count  : number of stored entries, 0..DEPTH
// -----------------------------------------------------------------------------
module fetchq_fifo
   import pipeline_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic                     i_clock,
   input  logic                     i_reset,
   input  logic                     i_flush,
   input  logic                     i_push,
   input  fetch_entry_t             i_data,
   input  logic                     i_pop,
   output fetch_entry_t             o_head,
   output logic                     o_empty,
   output logic [$clog2(DEPTH):0]   o_count
);

   localparam int unsigned AW = $clog2(DEPTH);

   localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};
   localparam logic [AW:0]   CNT_ONE  = {{AW{1'b0}}, 1'b1};
   localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

   fetch_entry_t   r_mem [DEPTH];
   logic [AW-1:0]  r_rd_ptr;
   logic [AW-1:0]  r_wr_ptr;
   logic [AW:0]    r_count;

   logic           w_empty;
   logic           w_full;
   logic           w_do_pop;
   logic           w_do_push;

   assign w_empty = (r_count == '0);
   assign w_full  = (r_count == CNT_FULL);

   // Guards keep the FIFO consistent even if the caller misbehaves; a push
   // into a full FIFO is accepted only when a pop frees a slot this cycle.
   assign w_do_pop  = i_pop  && !w_empty && !i_flush && !i_reset;
   assign w_do_push = i_push && (!w_full || w_do_pop) && !i_flush && !i_reset;

   always_ff @(posedge i_clock) begin
      if (i_reset || i_flush) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) begin
            r_wr_ptr <= r_wr_ptr + PTR_ONE;
         end
         if (w_do_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_ONE;
         end
         unique case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + CNT_ONE;
            2'b01:   r_count <= r_count - CNT_ONE;
            default: r_count <= r_count;
         endcase
      end
   end

   // Storage needs no reset: validity is tracked entirely by r_count.
   always_ff @(posedge i_clock) begin
      if (w_do_push) begin
         r_mem[r_wr_ptr] <= i_data;
      end
   end

   assign o_head  = r_mem[r_rd_ptr];
   assign o_empty = w_empty;
   assign o_count = r_count;

endmodule

// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
//   Instruction prefetch stage between IMEM and decode. Issues sequential word
//   reads, buffers returned {pc, insn} pairs in a FIFO, holds the head while
//   decode stalls, and flushes everything on a taken branch/jump.
//
//   Optional build macro: FETCH_QUEUE_STATS_EN adds flush_count and
//   stall_count outputs. Functional behaviour is identical either way.
//
//   Ports:
//     clock, reset       : rising-edge clock, synchronous active-high reset
//     stall              : decode cannot accept; head is held
//     do_branch          : taken branch/jump resolved in execute
//     pc_effective       : redirect target, valid with do_branch
//     imem_address       : IMEM word address (current fetch pc)
//     imem_access_size   : constant word access
//     imem_rw            : constant read
//     imem_enable        : request strobe
//     imem_data          : IMEM read data, valid the cycle after a request
//     pc_out, insn_out   : head entry (0 / NOP_INSN when empty)
//     insn_valid         : head entry present
//     occupancy          : buffered entry count
//     flush_count        : (stats) valid entries discarded by branches
//     stall_count        : (stats) cycles with stall && insn_valid
// -----------------------------------------------------------------------------
module fetch_queue
   import pipeline_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'h8002_0000,
   parameter int unsigned DEPTH     = 4,
   parameter logic [31:0] NOP_INSN  = pipeline_pkg::NOP_INSN
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     stall,
   input  logic                     do_branch,
   input  logic [WORD_W-1:0]        pc_effective,
   output logic [WORD_W-1:0]        imem_address,
   output logic [1:0]               imem_access_size,
   output logic                     imem_rw,
   output logic                     imem_enable,
   input  logic [WORD_W-1:0]        imem_data,
   output logic [WORD_W-1:0]        pc_out,
   output logic [WORD_W-1:0]        insn_out,
   output logic                     insn_valid,
   output logic [$clog2(DEPTH):0]   occupancy
`ifdef FETCH_QUEUE_STATS_EN
   ,
   output logic [31:0]              flush_count,
   output logic [31:0]              stall_count
`endif
);

   localparam int unsigned CW = $clog2(DEPTH) + 1;

   // One bit wider than occupancy so occupancy + inflight cannot overflow.
   localparam logic [CW:0] DEPTH_T = (CW+1)'(DEPTH);

   logic [WORD_W-1:0]   r_fetch_pc;
   logic [WORD_W-1:0]   r_inflight_pc;
   logic                r_inflight;

   logic                w_issue;
   logic                w_push;
   logic                w_pop;
   logic                w_empty;
   logic                w_valid;
   logic [CW-1:0]       w_occ;
   logic [CW:0]         w_total;
   fetch_entry_t        w_push_entry;
   fetch_entry_t        w_head;

   // Entries buffered plus the one still on its way back from IMEM; capping
   // requests on this sum guarantees every return has a FIFO slot.
   assign w_total = {1'b0, w_occ} + {{CW{1'b0}}, r_inflight};

   assign w_issue = !reset && !do_branch && (w_total < DEPTH_T);
   assign w_valid = !w_empty;
   assign w_push  = r_inflight && !do_branch;
   assign w_pop   = w_valid && !stall && !do_branch;

   assign w_push_entry.pc   = r_inflight_pc;
   assign w_push_entry.insn = imem_data;

   always_ff @(posedge clock) begin
      if (reset) begin
         r_fetch_pc    <= BASE_ADDR;
         r_inflight    <= 1'b0;
         r_inflight_pc <= '0;
      end else if (do_branch) begin
         // Drop the word returning next cycle and restart at the target.
         r_fetch_pc    <= pc_effective;
         r_inflight    <= 1'b0;
      end else begin
         r_inflight <= w_issue;
         if (w_issue) begin
            r_fetch_pc    <= r_fetch_pc + 32'd4;
            r_inflight_pc <= r_fetch_pc;
         end
      end
   end

   fetchq_fifo #(
      .DEPTH   (DEPTH)
   ) u_fifo (
      .i_clock (clock),
      .i_reset (reset),
      .i_flush (do_branch),
      .i_push  (w_push),
      .i_data  (w_push_entry),
      .i_pop   (w_pop),
      .o_head  (w_head),
      .o_empty (w_empty),
      .o_count (w_occ)
   );

   assign imem_address     = r_fetch_pc;
   assign imem_access_size = ACCESS_WORD;
   assign imem_rw          = RW_READ;
   assign imem_enable      = w_issue;

   assign insn_valid = w_valid;
   assign pc_out     = w_valid ? w_head.pc   : '0;
   assign insn_out   = w_valid ? w_head.insn : NOP_INSN;
   assign occupancy  = w_occ;

`ifdef FETCH_QUEUE_STATS_EN
   logic [31:0] r_flush_count;
   logic [31:0] r_stall_count;

   always_ff @(posedge clock) begin
      if (reset) begin
         r_flush_count <= '0;
         r_stall_count <= '0;
      end else begin
         if (do_branch) begin
            r_flush_count <= r_flush_count + 32'(w_total);
         end
         if (stall && w_valid) begin
            r_stall_count <= r_stall_count + 32'd1;
         end
      end
   end

   assign flush_count = r_flush_count;
   assign stall_count = r_stall_count;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// -----------------------------------------------------------------------------
// tb_fetch_queue
//   Directed bench for fetch_queue (BASE_ADDR=80020000, DEPTH=4). A behavioural
//   IMEM returns insn_of(address) one cycle after each address is presented.
//   Inputs change 1 time unit after a rising edge; outputs are checked 1 unit
//   later, well away from the next edge.
// -----------------------------------------------------------------------------
module tb_fetch_queue;

   logic        clock = 1'b0;
   logic        reset;
   logic        stall;
   logic        do_branch;
   logic [31:0] pc_effective;
   logic [31:0] imem_address;
   logic [1:0]  imem_access_size;
   logic        imem_rw;
   logic        imem_enable;
   logic [31:0] imem_data = 32'h0;
   logic [31:0] pc_out;
   logic [31:0] insn_out;
   logic        insn_valid;
   logic [2:0]  occupancy;
`ifdef FETCH_QUEUE_STATS_EN
   logic [31:0] flush_count;
   logic [31:0] stall_count;
`endif

   int tests = 0;
   int fails = 0;

   always #5 clock = ~clock;

   fetch_queue #(
      .BASE_ADDR        (32'h8002_0000),
      .DEPTH            (4),
      .NOP_INSN         (32'h0000_0000)
   ) dut (
      .clock            (clock),
      .reset            (reset),
      .stall            (stall),
      .do_branch        (do_branch),
      .pc_effective     (pc_effective),
      .imem_address     (imem_address),
      .imem_access_size (imem_access_size),
      .imem_rw          (imem_rw),
      .imem_enable      (imem_enable),
      .imem_data        (imem_data),
      .pc_out           (pc_out),
      .insn_out         (insn_out),
      .insn_valid       (insn_valid),
      .occupancy        (occupancy)
`ifdef FETCH_QUEUE_STATS_EN
      ,
      .flush_count      (flush_count),
      .stall_count      (stall_count)
`endif
   );

   function automatic logic [31:0] insn_of(input logic [31:0] a);
      return a ^ 32'hA5A5_F00F;
   endfunction

   // IMEM: data for the address seen at an edge is valid the following cycle.
   always @(posedge clock) imem_data <= insn_of(imem_address);

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Advance one clock; return 1 unit after the edge, ready to drive inputs.
   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   // Let combinational outputs settle after input changes.
   task automatic settle();
      #1;
   endtask

   initial begin
      reset        = 1'b1;
      stall        = 1'b0;
      do_branch    = 1'b0;
      pc_effective = 32'h0;
      cyc();
      cyc();

      // Reset state
      settle();
      chk("rst_enable",   {31'b0, imem_enable}, 32'h0);
      chk("rst_valid",    {31'b0, insn_valid},  32'h0);
      chk("rst_insn_out", insn_out,             32'h0000_0000);
      chk("rst_pc_out",   pc_out,               32'h0);
      chk("rst_occ",      {29'b0, occupancy},   32'h0);
      chk("const_size",   {30'b0, imem_access_size}, 32'h0);
      chk("const_rw",     {31'b0, imem_rw},     32'h1);

      // C0: first request right after reset release
      reset = 1'b0;
      settle();
      chk("c0_enable", {31'b0, imem_enable}, 32'h1);
      chk("c0_addr",   imem_address,         32'h8002_0000);
      cyc();
      // C1
      settle();
      chk("c1_addr",   imem_address,         32'h8002_0004);
      chk("c1_valid",  {31'b0, insn_valid},  32'h0);
      cyc();
      // C2: first entry valid two cycles after the first enable
      settle();
      chk("c2_valid",  {31'b0, insn_valid},  32'h1);
      chk("c2_pc",     pc_out,               32'h8002_0000);
      chk("c2_insn",   insn_out,             insn_of(32'h8002_0000));
      chk("c2_addr",   imem_address,         32'h8002_0008);
      // C3..C5: one instruction per cycle
      for (int i = 1; i <= 3; i++) begin
         cyc();
         settle();
         chk("stream_pc",  pc_out,             32'h8002_0000 + 32'(4 * i));
         chk("stream_occ", {29'b0, occupancy}, 32'h1);
      end

      // C5..C9: stall held five cycles, head stays at 8002000C
      stall = 1'b1;
      settle();
      chk("c5_enable", {31'b0, imem_enable}, 32'h1);
      chk("c5_addr",   imem_address,         32'h8002_0014);
      cyc();
      settle();
      chk("c6_pc",     pc_out,               32'h8002_000C);
      chk("c6_occ",    {29'b0, occupancy},   32'h2);
      cyc();
      settle();
      chk("c7_pc",     pc_out,               32'h8002_000C);
      chk("c7_enable", {31'b0, imem_enable}, 32'h0);
      cyc();
      settle();
      chk("c8_pc",     pc_out,               32'h8002_000C);
      chk("c8_occ",    {29'b0, occupancy},   32'h4);
      chk("c8_enable", {31'b0, imem_enable}, 32'h0);
      cyc();
      settle();
      chk("c9_pc",     pc_out,               32'h8002_000C);
      chk("c9_occ",    {29'b0, occupancy},   32'h4);
      cyc();

      // C10..C14: release, no loss and no duplication
      stall = 1'b0;
      settle();
      chk("c10_enable", {31'b0, imem_enable}, 32'h0);
      for (int i = 0; i < 5; i++) begin
         if (i != 0) begin
            cyc();
            settle();
         end
         chk("release_pc",   pc_out,   32'h8002_000C + 32'(4 * i));
         chk("release_insn", insn_out, insn_of(32'h8002_000C + 32'(4 * i)));
      end
      cyc();

      // C15: one stall cycle builds occupancy 3 with one fetch in flight
      stall = 1'b1;
      settle();
      chk("c15_occ", {29'b0, occupancy}, 32'h2);
      cyc();
      // C16: branch together with stall
      settle();
      chk("c16_occ", {29'b0, occupancy}, 32'h3);
      do_branch    = 1'b1;
      pc_effective = 32'h8002_0100;
      settle();
      chk("c16_enable", {31'b0, imem_enable}, 32'h0);
      cyc();
      // C17
      do_branch = 1'b0;
      stall     = 1'b0;
      settle();
      chk("c17_valid",  {31'b0, insn_valid},  32'h0);
      chk("c17_occ",    {29'b0, occupancy},   32'h0);
      chk("c17_addr",   imem_address,         32'h8002_0100);
      chk("c17_enable", {31'b0, imem_enable}, 32'h1);
`ifdef FETCH_QUEUE_STATS_EN
      chk("flush_count", flush_count, 32'd4);
      chk("stall_count", stall_count, 32'd7);
`endif
      cyc();
      // C18: the word returning from before the branch must not appear
      settle();
      chk("c18_valid", {31'b0, insn_valid}, 32'h0);
      cyc();
      // C19: target reaches decode
      settle();
      chk("c19_valid", {31'b0, insn_valid}, 32'h1);
      chk("c19_pc",    pc_out,              32'h8002_0100);
      chk("c19_insn",  insn_out,            insn_of(32'h8002_0100));

      // Back-to-back branches: only the last target is fetched
      do_branch    = 1'b1;
      pc_effective = 32'h8002_0040;
      cyc();
      pc_effective = 32'h8002_0080;
      settle();
      chk("bb_enable", {31'b0, imem_enable}, 32'h0);
      chk("bb_valid",  {31'b0, insn_valid},  32'h0);
      cyc();
      do_branch = 1'b0;
      settle();
      chk("bb_addr", imem_address, 32'h8002_0080);
      cyc();
      settle();
      chk("bb_valid2", {31'b0, insn_valid}, 32'h0);
      cyc();
      settle();
      chk("bb_pc0", pc_out, 32'h8002_0080);
      cyc();
      settle();
      chk("bb_pc1", pc_out, 32'h8002_0084);

      // Address wrap at FFFFFFFC
      do_branch    = 1'b1;
      pc_effective = 32'hFFFF_FFFC;
      cyc();
      do_branch = 1'b0;
      settle();
      chk("wrap_addr0", imem_address, 32'hFFFF_FFFC);
      cyc();
      settle();
      chk("wrap_addr1", imem_address, 32'h0000_0000);
      cyc();
      settle();
      chk("wrap_pc0", pc_out, 32'hFFFF_FFFC);
      cyc();
      settle();
      chk("wrap_pc1",   pc_out,   32'h0000_0000);
      chk("wrap_insn1", insn_out, insn_of(32'h0000_0000));

      // Reset mid-operation with occupancy 2 and a fetch in flight
      stall = 1'b1;
      cyc();
      settle();
      chk("pre_rst_occ", {29'b0, occupancy}, 32'h2);
      reset = 1'b1;
      stall = 1'b0;
      settle();
      chk("rst_hi_enable", {31'b0, imem_enable}, 32'h0);
      cyc();
      settle();
      chk("mid_rst_occ",    {29'b0, occupancy},   32'h0);
      chk("mid_rst_insn",   insn_out,             32'h0000_0000);
      chk("mid_rst_valid",  {31'b0, insn_valid},  32'h0);
      chk("mid_rst_enable", {31'b0, imem_enable}, 32'h0);
`ifdef FETCH_QUEUE_STATS_EN
      chk("rst_flush_count", flush_count, 32'd0);
      chk("rst_stall_count", stall_count, 32'd0);
`endif
      cyc();
      reset = 1'b0;
      settle();
      chk("rerun_addr",   imem_address,         32'h8002_0000);
      chk("rerun_enable", {31'b0, imem_enable}, 32'h1);
      cyc();
      cyc();
      settle();
      chk("rerun_pc", pc_out, 32'h8002_0000);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   // Global time bound so the bench always terminates.
   initial begin
      #100000;
      $display("FAIL timeout: observed no finish expected finish");
      $fatal(1, "bench timed out");
   end

endmodule
